// File: rtl/matrix_mac_engine_if.sv
// Job interface for matrix_mac_engine: A/B source handshake, C consumer handshake and mode bits.
// The master drives operands and c_ack; the engine (slave) returns C and status.
interface matrix_mac_engine_if #(
  parameter int unsigned M          = 16,
  parameter int unsigned P          = 16,
  parameter int unsigned N          = 16,
  parameter int unsigned WORD_WIDTH = 32
);
  logic [0:M*P*WORD_WIDTH-1] matrix_A;
  logic [0:P*N*WORD_WIDTH-1] matrix_B;
  logic                      a_stb;
  logic                      b_stb;
  logic                      signed_mode;
  logic                      sat_mode;
  logic                      c_ack;
  logic [0:M*N*WORD_WIDTH-1] matrix_C;
  logic                      c_stb;
  logic                      a_ack;
  logic                      b_ack;
  logic                      busy;
  logic                      overflow;

  modport master (
    output matrix_A, matrix_B, a_stb, b_stb, signed_mode, sat_mode, c_ack,
    input  matrix_C, c_stb, a_ack, b_ack, busy, overflow
  );

  modport slave (
    input  matrix_A, matrix_B, a_stb, b_stb, signed_mode, sat_mode, c_ack,
    output matrix_C, c_stb, a_ack, b_ack, busy, overflow
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// C = A x B with LANES parallel MACs; k sweeps fastest, then row group, then B column.
// Results are converted (saturate or truncate) as each dot product completes.
module matrix_mac_engine #(
  parameter int unsigned M          = 16,
  parameter int unsigned P          = 16,
  parameter int unsigned N          = 16,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_WIDTH  = 2 * WORD_WIDTH + $clog2(P) + 1
) (
  input logic                clk,
  input logic                rst,
  matrix_mac_engine_if.slave bus
);
  localparam int unsigned W      = WORD_WIDTH;
  localparam int unsigned GROUPS = M / LANES;
  localparam int unsigned KW     = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned JW     = (N > 1) ? $clog2(N) : 1;

  if ((M % LANES) != 0) begin : g_lanes_check
    $fatal(1, "matrix_mac_engine: M must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StWait, StCalc, StDone} state_e;
  state_e state_q, state_d;

  logic [0:M*P*W-1]            a_q;
  logic [0:P*N*W-1]            b_q;
  logic [0:M*N*W-1]            c_q;
  logic                        sgn_q, sat_q, ack_q, ovf_q;
  logic [KW-1:0]               k_q;
  logic [GW-1:0]               g_q;
  logic [JW-1:0]               j_q;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];

  logic                        accept, k_last, g_last, j_last;
  logic [W-1:0]                b_el;
  logic signed [W:0]           b_op;
  logic [W-1:0]                a_el  [LANES];
  logic signed [W:0]           a_op  [LANES];
  logic signed [2*W+1:0]       prod  [LANES];
  logic signed [ACC_WIDTH-1:0] sum   [LANES];
  logic [W-1:0]                word  [LANES];
  logic [LANES-1:0]            clip;

  assign accept = (state_q == StWait) && bus.a_stb && bus.b_stb;
  assign k_last = (k_q == KW'(P - 1));
  assign g_last = (g_q == GW'(GROUPS - 1));
  assign j_last = (j_q == JW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StWait;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (accept) state_d = StCalc;
      StCalc:  if (k_last && g_last && j_last) state_d = StDone;
      StDone:  if (bus.c_ack) state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  // Operands widened by one bit so one signed multiplier serves both modes.
  always_comb begin
    b_el = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];
    b_op = {sgn_q & b_el[W-1], b_el};
    clip = '0;
    for (int l = 0; l < LANES; l++) begin
      a_el[l] = a_q[((int'(g_q) * LANES + l) * P + int'(k_q)) * W +: W];
      a_op[l] = {sgn_q & a_el[l][W-1], a_el[l]};
      prod[l] = a_op[l] * b_op;
      sum[l]  = (k_q == '0) ? ACC_WIDTH'(prod[l]) : acc_q[l] + ACC_WIDTH'(prod[l]);
      word[l] = sum[l][W-1:0];
      // In range iff the bits above the result word are pure sign (or zero) extension.
      if (sgn_q) begin
        if ((sum[l][ACC_WIDTH-1:W-1] != '0) && (sum[l][ACC_WIDTH-1:W-1] != '1)) begin
          clip[l] = 1'b1;
          if (sat_q) begin
            word[l] = sum[l][ACC_WIDTH-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
        end
      end else if (sum[l][ACC_WIDTH-1:W] != '0) begin
        clip[l] = 1'b1;
        if (sat_q) word[l] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_q   <= '0;
      sgn_q <= 1'b0;
      sat_q <= 1'b0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
      k_q   <= '0;
      g_q   <= '0;
      j_q   <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        a_q   <= bus.matrix_A;
        b_q   <= bus.matrix_B;
        sgn_q <= bus.signed_mode;
        sat_q <= bus.sat_mode;
        ovf_q <= 1'b0;
        k_q   <= '0;
        g_q   <= '0;
        j_q   <= '0;
      end else if (state_q == StCalc) begin
        for (int l = 0; l < LANES; l++) acc_q[l] <= sum[l];
        if (k_last) begin
          k_q <= '0;
          for (int l = 0; l < LANES; l++) begin
            c_q[((int'(g_q) * LANES + l) * N + int'(j_q)) * W +: W] <= word[l];
          end
          if (|clip) ovf_q <= 1'b1;
          if (g_last) begin
            g_q <= '0;
            j_q <= j_last ? '0 : j_q + 1'b1;
          end else begin
            g_q <= g_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  assign bus.matrix_C = c_q;
  assign bus.c_stb    = (state_q == StDone);
  assign bus.a_ack    = ack_q;
  assign bus.b_ack    = ack_q;
  assign bus.busy     = (state_q != StWait);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: two engines (LANES=2 and LANES=4) share one stimulus stream
// and are checked against a plain-arithmetic matrix product model.
module tb_matrix_mac_engine;
  localparam int M    = 4;
  localparam int P    = 3;
  localparam int N    = 3;
  localparam int W    = 8;
  localparam int MPW  = M * P * W;
  localparam int PNW  = P * N * W;
  localparam int MNW  = M * N * W;
  localparam int LAT2 = N * (M / 2) * P;
  localparam int LAT4 = N * (M / 4) * P;

  logic           clk;
  logic           rst;
  logic [0:MPW-1] a_vec;
  logic [0:PNW-1] b_vec;
  logic           a_stb, b_stb, sgn, sat, c_ack;

  int             am [M][P];
  int             bm [P][N];
  logic [0:MNW-1] exp_c;
  logic           exp_ovf;
  bit             exp_valid;
  logic [0:MNW-1] got_c2;
  logic           got_ovf2;
  int             n_total, n_pass;

  matrix_mac_engine_if #(.M(M), .P(P), .N(N), .WORD_WIDTH(W)) if2 ();
  matrix_mac_engine_if #(.M(M), .P(P), .N(N), .WORD_WIDTH(W)) if4 ();

  assign if2.matrix_A = a_vec;  assign if4.matrix_A = a_vec;
  assign if2.matrix_B = b_vec;  assign if4.matrix_B = b_vec;
  assign if2.a_stb = a_stb;     assign if4.a_stb = a_stb;
  assign if2.b_stb = b_stb;     assign if4.b_stb = b_stb;
  assign if2.signed_mode = sgn; assign if4.signed_mode = sgn;
  assign if2.sat_mode = sat;    assign if4.sat_mode = sat;
  assign if2.c_ack = c_ack;     assign if4.c_ack = c_ack;

  matrix_mac_engine #(.M(M), .P(P), .N(N), .WORD_WIDTH(W), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  matrix_mac_engine #(.M(M), .P(P), .N(N), .WORD_WIDTH(W), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  task automatic check_c(input string name, input logic [0:MNW-1] got,
                         input logic [0:MNW-1] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic int elem(input logic [0:MNW-1] v, input int i, input int j);
    logic [W-1:0] e;
    e = v[(i*N+j)*W +: W];
    return int'(e);
  endfunction

  function automatic longint sval(input int raw, input bit s);
    return (s && raw >= (1 << (W - 1))) ? longint'(raw - (1 << W)) : longint'(raw);
  endfunction

  // Exact dot products, then clamp or wrap to W bits; overflow means any result differs.
  task automatic build_job(input bit s, input bit sa);
    longint sum, lo, hi, conv;
    sgn = s;
    sat = sa;
    for (int i = 0; i < M; i++)
      for (int c = 0; c < P; c++) a_vec[(i*P+c)*W +: W] = am[i][c][W-1:0];
    for (int k = 0; k < P; k++)
      for (int j = 0; j < N; j++) b_vec[(k*N+j)*W +: W] = bm[k][j][W-1:0];
    lo = s ? -(longint'(1) << (W - 1)) : 0;
    hi = s ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    exp_ovf = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < P; k++) sum += sval(am[i][k], s) * sval(bm[k][j], s);
        if (sa) begin
          conv = (sum < lo) ? lo : ((sum > hi) ? hi : sum);
        end else begin
          conv = sum & ((longint'(1) << W) - 1);
          if (s && conv > hi) conv -= (longint'(1) << W);
        end
        if (conv != sum) exp_ovf = 1'b1;
        exp_c[(i*N+j)*W +: W] = conv[W-1:0];
      end
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < M; i++) for (int c = 0; c < P; c++) am[i][c] = 0;
    for (int k = 0; k < P; k++) for (int j = 0; j < N; j++) bm[k][j] = 0;
  endtask

  function automatic int rand_elem(input bit s, input bit full);
    if (full) return int'($urandom_range(0, 255));
    if (s) return (int'($urandom_range(0, 6)) - 3) & 255;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic rand_mats(input bit s, input bit full);
    for (int i = 0; i < M; i++) for (int c = 0; c < P; c++) am[i][c] = rand_elem(s, full);
    for (int k = 0; k < P; k++) for (int j = 0; j < N; j++) bm[k][j] = rand_elem(s, full);
  endtask

  // Garbage on the inputs after acceptance: results must come from the latched job.
  task automatic scramble();
    for (int b = 0; b < MPW / 8; b++) a_vec[b*8 +: 8] = 8'($urandom_range(0, 255));
    for (int b = 0; b < PNW / 8; b++) b_vec[b*8 +: 8] = 8'($urandom_range(0, 255));
    sgn = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
  endtask

  task automatic run_job(input int hold_ack, input bit hold_strobes);
    int cyc, lat2, lat4, extra2, extra4;
    exp_valid = 1'b1;
    a_stb = 1'b1;
    b_stb = 1'b1;
    @(posedge clk); #1;
    check1("accept_ack_l2", if2.a_ack & if2.b_ack, 1'b1);
    check1("accept_ack_l4", if4.a_ack & if4.b_ack, 1'b1);
    check1("accept_busy", if2.busy & if4.busy, 1'b1);
    if (!hold_strobes) begin
      a_stb = 1'b0;
      b_stb = 1'b0;
    end
    scramble();
    lat2 = -1; lat4 = -1; extra2 = 0; extra4 = 0; cyc = 0;
    while ((lat2 < 0 || lat4 < 0) && cyc < 4 * LAT2) begin
      @(posedge clk); #1;
      cyc++;
      if (if2.a_ack || if2.b_ack) extra2++;
      if (if4.a_ack || if4.b_ack) extra4++;
      if (lat2 < 0 && if2.c_stb) lat2 = cyc;
      if (lat4 < 0 && if4.c_stb) lat4 = cyc;
    end
    check("latency_l2", lat2, LAT2);
    check("latency_l4", lat4, LAT4);
    check("extra_ack_l2", extra2, 0);
    check("extra_ack_l4", extra4, 0);
    a_stb = 1'b0;
    b_stb = 1'b0;
    got_c2   = if2.matrix_C;
    got_ovf2 = if2.overflow;
    repeat (hold_ack) begin
      @(posedge clk); #1;
      check1("hold_c_stb", if2.c_stb & if4.c_stb, 1'b1);
      check1("hold_busy", if2.busy & if4.busy, 1'b1);
    end
    c_ack = 1'b1;
    @(posedge clk); #1;
    c_ack = 1'b0;
    check1("release_c_stb", if2.c_stb | if4.c_stb, 1'b0);
    check1("release_busy", if2.busy | if4.busy, 1'b0);
  endtask

  task automatic check_idle_zero(input string name);
    check1({name, "_c_stb"}, if2.c_stb | if4.c_stb, 1'b0);
    check1({name, "_ack"}, if2.a_ack | if2.b_ack | if4.a_ack | if4.b_ack, 1'b0);
    check1({name, "_busy"}, if2.busy | if4.busy, 1'b0);
    check1({name, "_ovf"}, if2.overflow | if4.overflow, 1'b0);
    check1({name, "_c_zero"}, (|if2.matrix_C) | (|if4.matrix_C), 1'b0);
  endtask

  // Whenever C is presented it must equal the model for the accepted job.
  always @(negedge clk) begin
    if (rst && exp_valid) begin
      if (if2.c_stb) begin
        check_c("c_lanes2", if2.matrix_C, exp_c);
        check1("ovf_lanes2", if2.overflow, exp_ovf);
      end
      if (if4.c_stb) begin
        check_c("c_lanes4", if4.matrix_C, exp_c);
        check1("ovf_lanes4", if4.overflow, exp_ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_total = 0; n_pass = 0; exp_valid = 1'b0;
    rst = 1'b0; a_stb = 1'b0; b_stb = 1'b0; c_ack = 1'b0;
    sgn = 1'b0; sat = 1'b0; a_vec = '0; b_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b1;

    // Identity: top-left 2x2 of A passes through, with C held under backpressure.
    clear_mats();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    for (int k = 0; k < P; k++) bm[k][k] = 1;
    build_job(1'b0, 1'b1);
    check("model_id_00", elem(exp_c, 0, 0), 1);
    check("model_id_11", elem(exp_c, 1, 1), 4);
    run_job(10, 1'b0);
    check("id_c00", elem(got_c2, 0, 0), 1);
    check("id_c01", elem(got_c2, 0, 1), 2);
    check("id_c10", elem(got_c2, 1, 0), 3);
    check("id_c11", elem(got_c2, 1, 1), 4);
    check1("id_ovf", got_ovf2, 1'b0);

    // Signed operands, strobes held high for the whole calculation.
    clear_mats();
    am[0][0] = 253; am[0][1] = 2; am[1][0] = 1; am[1][1] = 255;
    bm[0][0] = 4; bm[0][1] = 255; bm[1][0] = 5; bm[1][1] = 2;
    build_job(1'b1, 1'b1);
    check("model_sgn_00", elem(exp_c, 0, 0), 'hFE);
    run_job(2, 1'b1);
    check("sgn_c00", elem(got_c2, 0, 0), 'hFE);
    check("sgn_c01", elem(got_c2, 0, 1), 'h07);
    check("sgn_c10", elem(got_c2, 1, 0), 'hFF);
    check("sgn_c11", elem(got_c2, 1, 1), 'hFD);

    // 200*2 + 200*2 = 800: saturates to 255, truncates to 0x20.
    clear_mats();
    am[0][0] = 200; am[0][1] = 200; bm[0][0] = 2; bm[1][0] = 2;
    build_job(1'b0, 1'b1);
    check("model_sat", elem(exp_c, 0, 0), 255);
    run_job(1, 1'b0);
    check("sat_c00", elem(got_c2, 0, 0), 255);
    check1("sat_ovf", got_ovf2, 1'b1);
    build_job(1'b0, 1'b0);
    check("model_trunc", elem(exp_c, 0, 0), 'h20);
    run_job(0, 1'b0);
    check("trunc_c00", elem(got_c2, 0, 0), 'h20);
    check1("trunc_ovf", got_ovf2, 1'b1);

    // A lone strobe and a stray c_ack must be ignored while idle.
    a_stb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check1("a_only_ack", if2.a_ack | if4.a_ack | if2.b_ack | if4.b_ack, 1'b0);
      check1("a_only_busy", if2.busy | if4.busy, 1'b0);
    end
    a_stb = 1'b0;
    b_stb = 1'b1;
    c_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check1("b_only_ack", if2.a_ack | if4.a_ack | if2.b_ack | if4.b_ack, 1'b0);
      check1("idle_c_stb", if2.c_stb | if4.c_stb, 1'b0);
    end
    b_stb = 1'b0;
    c_ack = 1'b0;

    // Reset halfway through a clipping job discards it entirely.
    rand_mats(1'b0, 1'b1);
    build_job(1'b0, 1'b1);
    exp_valid = 1'b1;
    a_stb = 1'b1; b_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0; b_stb = 1'b0;
    repeat (LAT4 / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("midreset");
    rst = 1'b1;
    cnt = 0;
    repeat (LAT2 + 2) begin
      @(posedge clk); #1;
      if (if2.c_stb || if4.c_stb || if2.busy || if4.busy) cnt++;
    end
    check("post_reset_activity", cnt, 0);
    rand_mats(1'b1, 1'b0);
    build_job(1'b1, 1'b0);
    run_job(1, 1'b0);

    // Randomized jobs across modes and magnitudes; a job may start right after DONE exits.
    for (int t = 0; t < 14; t++) begin
      bit s, sa, full;
      s    = 1'($urandom_range(0, 1));
      sa   = 1'($urandom_range(0, 1));
      full = 1'($urandom_range(0, 1));
      rand_mats(s, full);
      build_job(s, sa);
      run_job(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
